// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiplier and restoring divider share one 2*WIDTH accumulator; one step per clock.
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_div,
    input  logic             ifunsigned,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int ACCW = 2 * WIDTH;
    localparam int CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_neg);
        return is_neg ? ((~v) + WIDTH'(1)) : v;
    endfunction

    logic [1:0]       state_r;
    logic [CW-1:0]    cnt_r;
    logic [ACCW-1:0]  acc_r;
    logic [WIDTH-1:0] opb_r;
    logic             op_div_r;
    logic             neg_q_r;
    logic             neg_rem_r;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [ACCW-1:0]  mul_next_s;
    logic [WIDTH:0]   div_top_s;
    logic [WIDTH+1:0] div_diff_s;
    logic [ACCW-1:0]  div_next_s;
    logic [ACCW-1:0]  step_s;
    logic [ACCW-1:0]  prod_neg_s;

    // One iteration of either algorithm, selected by the latched op.
    always_comb begin
        a_neg_s    = ~ifunsigned & A[WIDTH-1];
        b_neg_s    = ~ifunsigned & B[WIDTH-1];
        // Multiply: low half holds the remaining multiplier bits, product grows from the top.
        mul_sum_s  = {1'b0, acc_r[ACCW-1:WIDTH]} + (acc_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
        mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        // Divide: the shifted remainder needs WIDTH+1 bits before the trial subtract.
        div_top_s  = acc_r[ACCW-1:WIDTH-1];
        div_diff_s = {1'b0, div_top_s} - {2'b00, opb_r};
        if (!div_diff_s[WIDTH+1]) begin
            div_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {acc_r[ACCW-2:0], 1'b0};
        end
        if (op_div_r) begin
            step_s = div_next_s;
        end else begin
            step_s = mul_next_s;
        end
        prod_neg_s = (~acc_r) + ACCW'(1);
    end

    // Control FSM, iteration datapath and HI/LO register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            acc_r     <= '0;
            opb_r     <= '0;
            op_div_r  <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dbz_r     <= 1'b0;
            hi_r      <= '0;
            lo_r      <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (op_div && (B == '0)) begin
                            hi_r   <= A;
                            lo_r   <= '1;
                            done_r <= 1'b1;
                            dbz_r  <= 1'b1;
                        end else begin
                            if (op_div) begin
                                acc_r <= {{WIDTH{1'b0}}, magnitude(A, a_neg_s)};
                                opb_r <= magnitude(B, b_neg_s);
                            end else begin
                                acc_r <= {{WIDTH{1'b0}}, magnitude(B, b_neg_s)};
                                opb_r <= magnitude(A, a_neg_s);
                            end
                            op_div_r  <= op_div;
                            neg_q_r   <= a_neg_s ^ b_neg_s;
                            neg_rem_r <= a_neg_s;
                            cnt_r     <= '0;
                            busy_r    <= 1'b1;
                            state_r   <= CALC;
                        end
                    end else begin
                        if (mthi) hi_r <= wdata;
                        if (mtlo) lo_r <= wdata;
                    end
                end
                CALC: begin
                    acc_r <= step_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == LAST_STEP) state_r <= FIX;
                end
                FIX: begin
                    if (op_div_r) begin
                        lo_r <= neg_q_r   ? magnitude(acc_r[WIDTH-1:0], 1'b1)    : acc_r[WIDTH-1:0];
                        hi_r <= neg_rem_r ? magnitude(acc_r[ACCW-1:WIDTH], 1'b1) : acc_r[ACCW-1:WIDTH];
                    end else begin
                        {hi_r, lo_r} <= neg_q_r ? prod_neg_s : acc_r;
                    end
                    dbz_r   <= 1'b0;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

endmodule
